// File: rtl/layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : layer_scheduler
// Brief    : Sequences a programmed chain of CNN layer ops (conv/relu/pool
//            engines) over shared memory. Each table entry launches one
//            engine, holds its bus grant until the engine reports done, then
//            clears the engine before moving to the next entry.
// Options  : LAYER_SCHED_TIMEOUT_EN - adds a WAIT watchdog; an engine that
//            stays silent for TIMEOUT_CYCLES is cleared and the program
//            aborts with err.
// Revision : 1.0 - initial release
// ============================================================================
module layer_scheduler #(
  parameter  int NUM_ENG        = 3,
  parameter  int ADDR_WIDTH     = 8,
  parameter  int NUM_LAYERS     = 8,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int ENG_W          = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1,
  localparam int LIDX_W         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [LIDX_W-1:0]     cfg_idx,
  input  logic [ENG_W-1:0]      cfg_eng,
  input  logic [ADDR_WIDTH-1:0] cfg_in_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_out_addr,
  input  logic                  cfg_last,
  input  logic                  run,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [LIDX_W-1:0]     cur_layer,
  output logic [NUM_ENG-1:0]    eng_start,
  output logic [NUM_ENG-1:0]    eng_clr,
  input  logic [NUM_ENG-1:0]    eng_done,
  output logic [ADDR_WIDTH-1:0] eng_in_addr,
  output logic [ADDR_WIDTH-1:0] eng_out_addr,
  output logic [NUM_ENG-1:0]    bus_grant
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_CLEAR  = 3'd4
  } state_t;

  localparam int              c_last_i   = NUM_LAYERS - 1;
  localparam logic [LIDX_W-1:0] c_last_idx = c_last_i[LIDX_W-1:0];
  localparam int              c_neng_i   = NUM_ENG;
  localparam logic [ENG_W:0]  c_num_eng  = c_neng_i[ENG_W:0];

  state_t r_state, w_state_nxt;

  // Program table
  logic [ENG_W-1:0]      r_tbl_eng  [NUM_LAYERS];
  logic [ADDR_WIDTH-1:0] r_tbl_in   [NUM_LAYERS];
  logic [ADDR_WIDTH-1:0] r_tbl_out  [NUM_LAYERS];
  logic                  r_tbl_last [NUM_LAYERS];

  // Entry currently being executed
  logic [ENG_W-1:0]      r_eng;
  logic [ADDR_WIDTH-1:0] r_in_addr;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic                  r_last;

  logic                  w_cfg_wr;
  logic                  w_load;
  logic [LIDX_W-1:0]     w_load_idx;
  logic                  w_byp;
  logic [ENG_W-1:0]      w_ld_eng;
  logic [ADDR_WIDTH-1:0] w_ld_in;
  logic [ADDR_WIDTH-1:0] w_ld_out;
  logic                  w_ld_last;
  logic                  w_clr_status;
  logic                  w_set_done;
  logic                  w_set_err;
  logic                  w_eng_bad;
  logic [NUM_ENG-1:0]    w_eng_oh;
  logic                  w_sel_done;
  logic                  w_wait_expired;
  logic                  w_timeout_abort;

  // One-hot decode of the latched engine index; out-of-range indices decode to zero
  generate
    for (genvar g = 0; g < NUM_ENG; g++) begin : g_dec
      assign w_eng_oh[g] = (r_eng == ENG_W'(g));
    end
  endgenerate

  assign w_eng_bad  = ({1'b0, r_eng} >= c_num_eng);
  // Only the granted engine's done level is observed
  assign w_sel_done = |(eng_done & w_eng_oh);
  assign w_cfg_wr   = (r_state == S_IDLE) && cfg_we;

  // A write landing in the same cycle as run must be visible to entry 0
  assign w_byp     = w_cfg_wr && (cfg_idx == w_load_idx);
  assign w_ld_eng  = w_byp ? cfg_eng      : r_tbl_eng[w_load_idx];
  assign w_ld_in   = w_byp ? cfg_in_addr  : r_tbl_in[w_load_idx];
  assign w_ld_out  = w_byp ? cfg_out_addr : r_tbl_out[w_load_idx];
  assign w_ld_last = w_byp ? cfg_last     : r_tbl_last[w_load_idx];

`ifdef LAYER_SCHED_TIMEOUT_EN
  localparam int               CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int               c_cmax_i  = TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] c_cnt_max = c_cmax_i[CNT_W-1:0];

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_timeout;
  logic             w_timeout_hit;

  // Watchdog counts WAIT cycles from zero; any other state rearms it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_timeout_hit;
      if (r_state != S_WAIT)
        r_wait_cnt <= '0;
      else
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  assign w_wait_expired  = (r_wait_cnt == c_cnt_max);
  assign w_timeout_abort = r_timeout;
`else
  localparam int c_unused_timeout = TIMEOUT_CYCLES;
  assign w_wait_expired  = 1'b0;
  assign w_timeout_abort = 1'b0;
`endif

  // State register; async reset drops every state-decoded output immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next-state logic and per-transition control strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_load_idx   = cur_layer;
    w_clr_status = 1'b0;
    w_set_done   = 1'b0;
    w_set_err    = 1'b0;
`ifdef LAYER_SCHED_TIMEOUT_EN
    w_timeout_hit = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_state_nxt  = S_FETCH;
          w_load       = 1'b1;
          w_load_idx   = '0;
          w_clr_status = 1'b1;
        end
      end
      S_FETCH: begin
        if (w_eng_bad) begin
          w_set_err   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_sel_done) begin
          w_state_nxt = S_CLEAR;
        end else if (w_wait_expired) begin
`ifdef LAYER_SCHED_TIMEOUT_EN
          w_timeout_hit = 1'b1;
`endif
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (w_timeout_abort) begin
          w_set_err   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_last || (cur_layer == c_last_idx)) begin
          w_set_done  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_load      = 1'b1;
          w_load_idx  = cur_layer + LIDX_W'(1);
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Program table: resets to single-entry programs, writable only while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        r_tbl_eng[i]  <= '0;
        r_tbl_in[i]   <= '0;
        r_tbl_out[i]  <= '0;
        r_tbl_last[i] <= 1'b1;
      end
    end else if (w_cfg_wr) begin
      r_tbl_eng[cfg_idx]  <= cfg_eng;
      r_tbl_in[cfg_idx]   <= cfg_in_addr;
      r_tbl_out[cfg_idx]  <= cfg_out_addr;
      r_tbl_last[cfg_idx] <= cfg_last;
    end
  end

  // Layer pointer, latched entry and sticky status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_layer  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      r_eng      <= '0;
      r_in_addr  <= '0;
      r_out_addr <= '0;
      r_last     <= 1'b0;
    end else begin
      if (w_clr_status) begin
        done <= 1'b0;
        err  <= 1'b0;
      end
      if (w_set_done)
        done <= 1'b1;
      if (w_set_err)
        err <= 1'b1;
      if (w_load) begin
        cur_layer  <= w_load_idx;
        r_eng      <= w_ld_eng;
        r_in_addr  <= w_ld_in;
        r_out_addr <= w_ld_out;
        r_last     <= w_ld_last;
      end
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign eng_start    = (r_state == S_LAUNCH) ? w_eng_oh : '0;
  assign bus_grant    = ((r_state == S_LAUNCH) || (r_state == S_WAIT)) ? w_eng_oh : '0;
  assign eng_clr      = (r_state == S_CLEAR) ? w_eng_oh : '0;
  assign eng_in_addr  = r_in_addr;
  assign eng_out_addr = r_out_addr;

endmodule
`default_nettype wire

// File: tb/tb_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_scheduler
// Brief    : Directed bench for layer_scheduler with stub engines (done 5
//            cycles after start, dropped on clr) and a timeline model that
//            derives every cycle's expected outputs from the per-layer
//            FETCH/LAUNCH/WAIT/CLEAR schedule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_scheduler;
  localparam int NUM_ENG    = 3;
  localparam int ADDR_WIDTH = 8;
  localparam int NUM_LAYERS = 8;
  localparam int TMO        = 16;
  localparam int STUB_WAIT  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_idx = '0;
  logic [1:0] cfg_eng = '0;
  logic [7:0] cfg_in_addr = '0;
  logic [7:0] cfg_out_addr = '0;
  logic       cfg_last = 1'b0;
  logic       run = 1'b0;
  logic       busy, done, err;
  logic [2:0] cur_layer, eng_start, eng_clr, eng_done, bus_grant;
  logic [7:0] eng_in_addr, eng_out_addr;

  layer_scheduler #(
    .NUM_ENG(NUM_ENG), .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_LAYERS(NUM_LAYERS), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_eng(cfg_eng),
    .cfg_in_addr(cfg_in_addr), .cfg_out_addr(cfg_out_addr), .cfg_last(cfg_last),
    .run(run), .busy(busy), .done(done), .err(err), .cur_layer(cur_layer),
    .eng_start(eng_start), .eng_clr(eng_clr), .eng_done(eng_done),
    .eng_in_addr(eng_in_addr), .eng_out_addr(eng_out_addr), .bus_grant(bus_grant)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub engines
  int         stub_cnt [NUM_ENG];
  logic [2:0] stub_done;
  logic [2:0] stub_en = 3'b111;
  logic [2:0] inj = 3'b000;
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < NUM_ENG; i++) begin
      if (rst) begin
        stub_cnt[i]  <= 0;
        stub_done[i] <= 1'b0;
      end else if (eng_clr[i]) begin
        stub_cnt[i]  <= 0;
        stub_done[i] <= 1'b0;
      end else if (eng_start[i]) begin
        stub_cnt[i] <= 1;
      end else if (stub_cnt[i] != 0 && !stub_done[i] && stub_en[i]) begin
        if (stub_cnt[i] == STUB_WAIT - 1) stub_done[i] <= 1'b1;
        stub_cnt[i] <= stub_cnt[i] + 1;
      end
    end
  end
  assign eng_done = stub_done | inj;

  // Model: table as the bench wrote it, plus a snapshot taken at each run
  int         m_tbl_eng  [NUM_LAYERS];
  logic [7:0] m_tbl_in   [NUM_LAYERS];
  logic [7:0] m_tbl_out  [NUM_LAYERS];
  bit         m_tbl_last [NUM_LAYERS];
  int         m_prog_eng [NUM_LAYERS];
  logic [7:0] m_prog_in  [NUM_LAYERS];
  logic [7:0] m_prog_out [NUM_LAYERS];
  bit         m_prog_last[NUM_LAYERS];
  bit         m_active = 1'b0;
  bit         m_check  = 1'b0;
  int         m_run_cyc = 0;
  int         m_wait = STUB_WAIT;
  bit         m_hang = 1'b0;
  int         m_pwait = STUB_WAIT;
  bit         m_phang = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic       addr_chk;
    logic [2:0] layer;
    logic [2:0] start;
    logic [2:0] clr;
    logic [2:0] grant;
    logic [7:0] in_a;
    logic [7:0] out_a;
  } exp_t;

  task automatic model_reset_table();
    for (int i = 0; i < NUM_LAYERS; i++) begin
      m_tbl_eng[i] = 0; m_tbl_in[i] = 8'h00; m_tbl_out[i] = 8'h00; m_tbl_last[i] = 1'b1;
    end
  endtask

  // Expected outputs t cycles after the cycle in which run was applied.
  // Each layer occupies FETCH, LAUNCH, m_pwait WAIT cycles and CLEAR.
  function automatic exp_t model(input int t);
    exp_t e;
    int rem, per;
    logic [2:0] oh;
    e = '0;
    if (!m_active) return e;
    per = m_pwait + 3;
    rem = t - 1;
    for (int L = 0; L < NUM_LAYERS; L++) begin
      e.layer = L[2:0];
      if (m_prog_eng[L] >= NUM_ENG) begin
        if (rem == 0) e.busy = 1'b1;
        else          e.err  = 1'b1;
        return e;
      end
      if (rem < per) begin
        oh = 3'b001 << m_prog_eng[L];
        e.busy     = 1'b1;
        e.addr_chk = 1'b1;
        e.in_a     = m_prog_in[L];
        e.out_a    = m_prog_out[L];
        if (rem == 1) e.start = oh;
        if (rem >= 1 && rem <= per - 2) e.grant = oh;
        if (rem == per - 1) e.clr = oh;
        return e;
      end
      rem = rem - per;
      if (m_phang) begin
        e.err = 1'b1;
        return e;
      end
      if (m_prog_last[L] || L == NUM_LAYERS - 1) begin
        e.done = 1'b1;
        return e;
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the timeline model
  exp_t cmp_e;
  always @(negedge clk) begin
    if (m_check && !rst) begin
      cmp_e = model(cyc - m_run_cyc);
      chk("busy",      32'(busy),      32'(cmp_e.busy));
      chk("done",      32'(done),      32'(cmp_e.done));
      chk("err",       32'(err),       32'(cmp_e.err));
      chk("cur_layer", 32'(cur_layer), 32'(cmp_e.layer));
      chk("eng_start", 32'(eng_start), 32'(cmp_e.start));
      chk("eng_clr",   32'(eng_clr),   32'(cmp_e.clr));
      chk("bus_grant", 32'(bus_grant), 32'(cmp_e.grant));
      chk("grant_onehot", 32'($countones(bus_grant) <= 1), 32'd1);
      if (cmp_e.addr_chk || !m_active) begin
        chk("eng_in_addr",  32'(eng_in_addr),  32'(cmp_e.in_a));
        chk("eng_out_addr", 32'(eng_out_addr), 32'(cmp_e.out_a));
      end
    end
  end

  // One cycle of config write and/or run
  task automatic apply(input bit do_cfg, input int idx, input int eng, input logic [7:0] ia,
                       input logic [7:0] oa, input bit last, input bit do_run);
    exp_t e;
    bit   idle_now;
    @(negedge clk); #1;
    e = model(cyc - m_run_cyc);
    idle_now = !e.busy;
    cfg_we = do_cfg; cfg_idx = idx[2:0]; cfg_eng = eng[1:0];
    cfg_in_addr = ia; cfg_out_addr = oa; cfg_last = last;
    if (do_cfg && idle_now) begin
      m_tbl_eng[idx] = eng; m_tbl_in[idx] = ia; m_tbl_out[idx] = oa; m_tbl_last[idx] = last;
    end
    run = do_run;
    @(posedge clk); #1;
    cfg_we = 1'b0; run = 1'b0;
    if (do_run && idle_now) begin
      m_prog_eng = m_tbl_eng; m_prog_in = m_tbl_in; m_prog_out = m_tbl_out; m_prog_last = m_tbl_last;
      m_pwait = m_wait; m_phang = m_hang;
      m_run_cyc = cyc - 1;
      m_active  = 1'b1;
    end
  endtask

  logic [2:0] g_starts[$];
  int g_first_start_t, g_first_clr_t, g_end_t;

  // Follow a program until busy falls; optional done glitch on engine 2 and a write while busy
  task automatic go(input int inj_t, input int wb_t);
    int   t;
    bit   fin;
    exp_t e;
    g_starts.delete();
    g_first_start_t = -1; g_first_clr_t = -1; g_end_t = -1;
    fin = 1'b0;
    for (int k = 0; k < 300 && !fin; k++) begin
      @(negedge clk);
      t = cyc - m_run_cyc;
      if (eng_start != 3'b000) begin
        g_starts.push_back(eng_start);
        if (g_first_start_t < 0) g_first_start_t = t;
      end
      if (eng_clr != 3'b000 && g_first_clr_t < 0) g_first_clr_t = t;
      inj = (inj_t > 0 && t >= inj_t && t < inj_t + 2) ? 3'b100 : 3'b000;
      if (wb_t > 0 && t == wb_t) begin
        e = model(t);
        cfg_we = 1'b1; cfg_idx = 3'd0; cfg_eng = 2'd2;
        cfg_in_addr = 8'hAA; cfg_out_addr = 8'hBB; cfg_last = 1'b1;
        if (!e.busy) begin
          m_tbl_eng[0] = 2; m_tbl_in[0] = 8'hAA; m_tbl_out[0] = 8'hBB; m_tbl_last[0] = 1'b1;
        end
      end else begin
        cfg_we = 1'b0;
      end
      if (t >= 1 && !busy) begin
        g_end_t = t;
        fin = 1'b1;
      end
    end
    inj = 3'b000;
    cfg_we = 1'b0;
    if (!fin) chk("program_finish", 32'd0, 32'd1);
  endtask

  initial begin
    model_reset_table();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_busy",      32'(busy),      32'd0);
    chk("reset_done",      32'(done),      32'd0);
    chk("reset_err",       32'(err),       32'd0);
    chk("reset_cur_layer", 32'(cur_layer), 32'd0);
    chk("reset_grant",     32'(bus_grant), 32'd0);
    chk("reset_start",     32'(eng_start), 32'd0);
    chk("reset_clr",       32'(eng_clr),   32'd0);
    chk("reset_in_addr",   32'(eng_in_addr), 32'd0);
    m_check = 1'b1;

    // 1: three-layer chain eng0 -> eng1 -> eng2
    apply(1, 0, 0, 8'h00, 8'h10, 0, 0);
    apply(1, 1, 1, 8'h10, 8'h20, 0, 0);
    apply(1, 2, 2, 8'h20, 8'h30, 1, 0);
    apply(0, 0, 0, 8'h00, 8'h00, 0, 1);
    go(0, 0);
    chk("t1_nstarts", 32'(g_starts.size()), 32'd3);
    if (g_starts.size() == 3) begin
      chk("t1_start0", 32'(g_starts[0]), 32'b001);
      chk("t1_start1", 32'(g_starts[1]), 32'b010);
      chk("t1_start2", 32'(g_starts[2]), 32'b100);
    end
    chk("t1_end_t", 32'(g_end_t), 32'd25);
    chk("t1_done",  32'(done),    32'd1);

    // 7: no last flag anywhere -> stops after the final table entry
    for (int i = 0; i < NUM_LAYERS; i++)
      apply(1, i, i % 3, 8'(i * 16), 8'(i * 16 + 8), 0, 0);
    apply(0, 0, 0, 8'h00, 8'h00, 0, 1);
    go(0, 0);
    chk("t7_nstarts", 32'(g_starts.size()), 32'd8);
    chk("t7_end_t",   32'(g_end_t), 32'd65);

    // 2: single entry eng1, rerun; table write while busy is dropped
    apply(1, 0, 1, 8'h40, 8'h50, 1, 0);
    apply(0, 0, 0, 8'h00, 8'h00, 0, 1);
    go(0, 3);
    chk("t2_first_start_t", 32'(g_first_start_t), 32'd2);
    chk("t2_end_t",         32'(g_end_t), 32'd9);
    apply(0, 0, 0, 8'h00, 8'h00, 0, 1);
    go(0, 0);
    chk("t2_rerun_nstarts", 32'(g_starts.size()), 32'd1);
    if (g_starts.size() == 1) chk("t2_rerun_start", 32'(g_starts[0]), 32'b010);
    chk("t2_rerun_done", 32'(done), 32'd1);

    // 3: engine index out of range
    apply(1, 0, 3, 8'h00, 8'h00, 1, 0);
    apply(0, 0, 0, 8'h00, 8'h00, 0, 1);
    go(0, 0);
    chk("t3_nstarts", 32'(g_starts.size()), 32'd0);
    chk("t3_end_t",   32'(g_end_t), 32'd2);
    chk("t3_err",     32'(err),     32'd1);

    // 4: write and run in the same cycle; stray done from eng2 during eng0 WAIT
    apply(1, 0, 0, 8'h11, 8'h22, 1, 1);
    go(4, 0);
    chk("t4_end_t", 32'(g_end_t), 32'd9);
    chk("t4_nstarts", 32'(g_starts.size()), 32'd1);
    if (g_starts.size() == 1) chk("t4_start", 32'(g_starts[0]), 32'b001);

`ifdef LAYER_SCHED_TIMEOUT_EN
    // 5: engine never finishes -> watchdog abort
    apply(1, 0, 0, 8'h33, 8'h44, 1, 0);
    stub_en[0] = 1'b0;
    m_wait = TMO;
    m_hang = 1'b1;
    apply(0, 0, 0, 8'h00, 8'h00, 0, 1);
    go(0, 0);
    chk("t5_first_clr_t", 32'(g_first_clr_t), 32'd19);
    chk("t5_end_t",       32'(g_end_t), 32'd20);
    chk("t5_err",         32'(err),  32'd1);
    chk("t5_done",        32'(done), 32'd0);
    stub_en[0] = 1'b1;
    m_wait = STUB_WAIT;
    m_hang = 1'b0;
`endif

    // 6: reset in the middle of WAIT, then run the restored table
    apply(1, 0, 2, 8'h05, 8'h06, 1, 0);
    apply(0, 0, 0, 8'h00, 8'h00, 0, 1);
    for (int k = 0; k < 20 && (cyc - m_run_cyc) != 5; k++) @(negedge clk);
    chk("t6_in_wait", 32'(bus_grant), 32'b100);
    m_check = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_grant", 32'(bus_grant), 32'd0);
    chk("t6_rst_busy",  32'(busy),      32'd0);
    chk("t6_rst_clr",   32'(eng_clr),   32'd0);
    model_reset_table();
    m_active = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1 m_check = 1'b1;
    apply(0, 0, 0, 8'h00, 8'h00, 0, 1);
    go(0, 0);
    chk("t6_nstarts", 32'(g_starts.size()), 32'd1);
    if (g_starts.size() == 1) chk("t6_start", 32'(g_starts[0]), 32'b001);
    chk("t6_end_t", 32'(g_end_t), 32'd9);

    repeat (3) @(negedge clk);
    m_check = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
